// File: rtl/ap_prof_pkg.sv
// Shared types and helpers for the HLS block-level handshake profiler.
//   prof_state_t : per-channel FSM state (IDLE, BUSY, DONE_WAIT)
//   ST_W         : width of the exported state field
//   sat_inc      : saturating increment of a value held in the low w bits
//   idx_w        : readout index width for a given channel count (min 1)
package ap_prof_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } prof_state_t;

  // Value lives in the low w bits; the result sticks at all-ones for width w.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ap_ch_profiler.sv
// One channel of the handshake profiler: tracks the ap_start/ap_done/
// ap_continue protocol and accumulates busy, stall, transaction and
// maximum-latency statistics.
// Ports:
//   clock, reset (sync, active-low)
//   start/ready/done/cont : the channel's handshake signals
//   mode   : 0 full handshake, 1 count ap_ready pulses only
//   enable : statistics accumulate only when 1
//   clr    : zero statistics and in-flight latency (FSM untouched)
//   frz    : statistics frozen (FSM keeps tracking)
//   busy/stall/max_lat/txn : accumulated statistics
//   ch_state : current FSM state
module ap_ch_profiler
  import ap_prof_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TXN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             ready,
  input  logic             done,
  input  logic             cont,
  input  logic             mode,
  input  logic             enable,
  input  logic             clr,
  input  logic             frz,
  output logic [CNT_W-1:0] busy,
  output logic [CNT_W-1:0] stall,
  output logic [CNT_W-1:0] max_lat,
  output logic [TXN_W-1:0] txn,
  output logic [ST_W-1:0]  ch_state
);

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), CNT_W));
  endfunction

  function automatic logic [TXN_W-1:0] inc_txn(input logic [TXN_W-1:0] v);
    return TXN_W'(sat_inc(64'(v), TXN_W));
  endfunction

  prof_state_t      state, state_nxt;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] lat_fin;
  logic             run_start;
  logic             busy_cyc;
  logic             stall_cyc;
  logic             txn_evt;
  logic             lat_done;
  logic             upd;

  // Latency including the current (done) cycle, so a run counts start..done.
  assign lat_fin  = inc_cnt(lat);
  assign upd      = enable & ~frz;
  assign ch_state = state;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_start = 1'b0;
    busy_cyc  = 1'b0;
    stall_cyc = 1'b0;
    txn_evt   = 1'b0;
    lat_done  = 1'b0;
    if (mode) begin
      state_nxt = IDLE;
      txn_evt   = ready;
    end else begin
      case (state)
        IDLE: begin
          // The start cycle itself is the first busy/latency cycle.
          if (start) begin
            state_nxt = BUSY;
            run_start = 1'b1;
            busy_cyc  = 1'b1;
          end
        end
        BUSY: begin
          busy_cyc = 1'b1;
          if (done) begin
            txn_evt  = 1'b1;
            lat_done = 1'b1;
            if (!cont)      state_nxt = DONE_WAIT;
            else if (start) run_start = 1'b1;
            else            state_nxt = IDLE;
          end
        end
        DONE_WAIT: begin
          stall_cyc = 1'b1;
          if (cont) begin
            if (start) begin
              state_nxt = BUSY;
              run_start = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // In-flight latency follows the FSM even when the statistics are gated.
  always_ff @(posedge clock) begin
    if (!reset || clr)        lat <= '0;
    else if (run_start)       lat <= {{(CNT_W-1){1'b0}}, 1'b1};
    else if (state == BUSY)   lat <= lat_fin;
  end

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      busy    <= '0;
      stall   <= '0;
      max_lat <= '0;
      txn     <= '0;
    end else if (upd) begin
      if (busy_cyc)                       busy    <= inc_cnt(busy);
      if (stall_cyc)                      stall   <= inc_cnt(stall);
      if (txn_evt)                        txn     <= inc_txn(txn);
      if (lat_done && (lat_fin > max_lat)) max_lat <= lat_fin;
    end
  end

endmodule

// File: rtl/ap_status_profiler.sv
// Multi-channel profiler for HLS block-level control handshakes.
// Holds the freeze/clear control, one ap_ch_profiler per channel and a
// registered channel-indexed readout.
// Ports:
//   clock, reset (sync, active-low)
//   ap_start/ap_ready/ap_done/ap_continue [NUM_CH] : monitored handshakes
//   ch_mode, ch_enable [NUM_CH] : per-channel mode and accumulate enable
//   clr    : clear all statistics and frozen
//   finish : freeze request; frozen reports the frozen status
//   rd_req, rd_ch : readout request and channel index
//   rd_valid, rd_busy, rd_stall, rd_txn, rd_max_lat, rd_state : readout data
module ap_status_profiler
  import ap_prof_pkg::*;
#(
  parameter  int NUM_CH = 24,
  parameter  int CNT_W  = 32,
  parameter  int TXN_W  = 16,
  localparam int CH_W   = idx_w(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [NUM_CH-1:0] ch_mode,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              clr,
  input  logic              finish,
  output logic              frozen,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_busy,
  output logic [CNT_W-1:0]  rd_stall,
  output logic [TXN_W-1:0]  rd_txn,
  output logic [CNT_W-1:0]  rd_max_lat,
  output logic [1:0]        rd_state
);

  logic [CNT_W-1:0] busy_a  [NUM_CH];
  logic [CNT_W-1:0] stall_a [NUM_CH];
  logic [CNT_W-1:0] mlat_a  [NUM_CH];
  logic [TXN_W-1:0] txn_a   [NUM_CH];
  logic [ST_W-1:0]  st_a    [NUM_CH];

  // Updates sampled in the finish cycle still commit: gating uses the
  // registered flag, which only rises on the following edge.
  always_ff @(posedge clock) begin
    if (!reset || clr) frozen <= 1'b0;
    else if (finish)   frozen <= 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_ch_profiler #(
      .CNT_W (CNT_W),
      .TXN_W (TXN_W)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .start    (ap_start[g]),
      .ready    (ap_ready[g]),
      .done     (ap_done[g]),
      .cont     (ap_continue[g]),
      .mode     (ch_mode[g]),
      .enable   (ch_enable[g]),
      .clr      (clr),
      .frz      (frozen),
      .busy     (busy_a[g]),
      .stall    (stall_a[g]),
      .max_lat  (mlat_a[g]),
      .txn      (txn_a[g]),
      .ch_state (st_a[g])
    );
  end

  logic             in_range;
  logic             vld_p1;
  logic [CNT_W-1:0] busy_p1;
  logic [CNT_W-1:0] stall_p1;
  logic [CNT_W-1:0] mlat_p1;
  logic [TXN_W-1:0] txn_p1;
  logic [ST_W-1:0]  st_p1;

  assign in_range = (int'(rd_ch) < NUM_CH);

  // Stage p0 -> p1: readout register, one request per cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      busy_p1  <= '0;
      stall_p1 <= '0;
      mlat_p1  <= '0;
      txn_p1   <= '0;
      st_p1    <= '0;
    end else begin
      vld_p1 <= rd_req;
      if (rd_req) begin
        if (in_range) begin
          busy_p1  <= busy_a[rd_ch];
          stall_p1 <= stall_a[rd_ch];
          mlat_p1  <= mlat_a[rd_ch];
          txn_p1   <= txn_a[rd_ch];
          st_p1    <= st_a[rd_ch];
        end else begin
          busy_p1  <= '0;
          stall_p1 <= '0;
          mlat_p1  <= '0;
          txn_p1   <= '0;
          st_p1    <= '0;
        end
      end
    end
  end

  assign rd_valid   = vld_p1;
  assign rd_busy    = busy_p1;
  assign rd_stall   = stall_p1;
  assign rd_max_lat = mlat_p1;
  assign rd_txn     = txn_p1;
  assign rd_state   = st_p1;

endmodule

// File: tb/tb_ap_status_profiler.sv
// Directed bench for ap_status_profiler with small counters so saturation
// is reachable: 6 channels, 4-bit busy/stall/latency, 8-bit transactions.
module tb_ap_status_profiler;

  localparam int NCH  = 6;
  localparam int CW   = 4;
  localparam int TW   = 8;
  localparam int CHW  = 3;

  logic            clock;
  logic            reset;
  logic [NCH-1:0]  ap_start, ap_ready, ap_done, ap_continue, ch_mode, ch_enable;
  logic            clr, finish, frozen, rd_req, rd_valid;
  logic [CHW-1:0]  rd_ch;
  logic [CW-1:0]   rd_busy, rd_stall, rd_max_lat;
  logic [TW-1:0]   rd_txn;
  logic [1:0]      rd_state;

  int nvec = 0;
  int nerr = 0;

  ap_status_profiler #(.NUM_CH(NCH), .CNT_W(CW), .TXN_W(TW)) dut (
    .clock       (clock),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .ch_mode     (ch_mode),
    .ch_enable   (ch_enable),
    .clr         (clr),
    .finish      (finish),
    .frozen      (frozen),
    .rd_req      (rd_req),
    .rd_ch       (rd_ch),
    .rd_valid    (rd_valid),
    .rd_busy     (rd_busy),
    .rd_stall    (rd_stall),
    .rd_txn      (rd_txn),
    .rd_max_lat  (rd_max_lat),
    .rd_state    (rd_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input int ch);
    rd_req = 1'b1;
    rd_ch  = CHW'(ch);
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; finish = 1'b0;
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    ch_mode = 6'b100000; ch_enable = '1;
    rd_req = 1'b1; rd_ch = '0;
    ticks(3);
    chk("reset_valid", rd_valid, 0);
    chk("reset_frozen", frozen, 0);
    chk("reset_busy", rd_busy, 0);
    chk("reset_state", rd_state, 0);
    reset = 1'b1; rd_req = 1'b0;
    tick();

    // Channel 0: start, three busy cycles, done with continue.
    ap_start[0] = 1'b1; tick();
    ap_start[0] = 1'b0; ticks(3);
    ap_done[0] = 1'b1; tick();
    ap_done[0] = 1'b0;
    rd(0);
    chk("c0_valid", rd_valid, 1);
    chk("c0_txn", rd_txn, 1);
    chk("c0_busy", rd_busy, 5);
    chk("c0_maxlat", rd_max_lat, 5);
    chk("c0_stall", rd_stall, 0);
    chk("c0_state", rd_state, 0);
    tick();
    chk("c0_valid_drop", rd_valid, 0);

    // Channel 3: done without continue, six cycles waiting.
    ap_start[3] = 1'b1; tick();
    ap_start[3] = 1'b0; ap_done[3] = 1'b1; ap_continue[3] = 1'b0; tick();
    ap_done[3] = 1'b0;
    rd(3);
    chk("c3_state_dw", rd_state, 2);
    chk("c3_stall_mid", rd_stall, 0);
    ticks(4);
    ap_continue[3] = 1'b1; tick();
    rd(3);
    chk("c3_stall", rd_stall, 6);
    chk("c3_state", rd_state, 0);
    chk("c3_txn", rd_txn, 1);
    chk("c3_busy", rd_busy, 2);

    // Channel 1: back-to-back runs of 4 and 7 cycles.
    ap_start[1] = 1'b1; tick();
    ap_start[1] = 1'b0; ticks(2);
    ap_start[1] = 1'b1; ap_done[1] = 1'b1; tick();
    ap_start[1] = 1'b0; ap_done[1] = 1'b0;
    rd(1);
    chk("b2b_state_mid", rd_state, 1);
    chk("b2b_maxlat_mid", rd_max_lat, 4);
    chk("b2b_busy_mid", rd_busy, 4);
    ticks(4);
    ap_done[1] = 1'b1; tick();
    ap_done[1] = 1'b0;
    rd(1);
    chk("b2b_txn", rd_txn, 2);
    chk("b2b_maxlat", rd_max_lat, 7);
    chk("b2b_busy", rd_busy, 10);
    chk("b2b_state", rd_state, 0);

    // Channel 5 ready-only: start/done must not move its FSM.
    ap_ready[5] = 1'b1; ap_start[5] = 1'b1; ap_done[5] = 1'b1; tick();
    ap_ready[5] = 1'b0; ap_start[5] = 1'b0; ap_done[5] = 1'b0; tick();
    ap_ready[5] = 1'b1; tick();
    ap_ready[5] = 1'b0; tick();
    ap_ready[5] = 1'b1; tick();
    ap_ready[5] = 1'b0;
    rd(5);
    chk("m1_txn", rd_txn, 3);
    chk("m1_busy", rd_busy, 0);
    chk("m1_maxlat", rd_max_lat, 0);
    chk("m1_state", rd_state, 0);
    rd(6);
    chk("oor_valid", rd_valid, 1);
    chk("oor_txn", rd_txn, 0);
    chk("oor_state", rd_state, 0);

    // Channel 2: 20-cycle run saturates 4-bit busy and latency.
    ap_start[2] = 1'b1; tick();
    ap_start[2] = 1'b0; ticks(19);
    rd(2);
    chk("sat_busy", rd_busy, 15);
    ap_done[2] = 1'b1; tick();
    ap_done[2] = 1'b0;
    rd(2);
    chk("sat_maxlat", rd_max_lat, 15);
    chk("sat_txn", rd_txn, 1);

    // Channel 4 disabled: state tracked, no statistics.
    ch_enable[4] = 1'b0;
    ap_start[4] = 1'b1; tick();
    ap_start[4] = 1'b0;
    rd(4);
    chk("dis_state", rd_state, 1);
    chk("dis_busy", rd_busy, 0);
    ap_done[4] = 1'b1; tick();
    ap_done[4] = 1'b0;
    rd(4);
    chk("dis_txn", rd_txn, 0);
    chk("dis_state_idle", rd_state, 0);
    ch_enable[4] = 1'b1;

    // Freeze during a channel 0 run; the finish cycle still counts.
    ap_start[0] = 1'b1; tick();
    ap_start[0] = 1'b0; tick();
    chk("pre_finish_frozen", frozen, 0);
    finish = 1'b1; tick();
    finish = 1'b0;
    chk("finish_frozen", frozen, 1);
    ticks(10);
    rd(0);
    chk("frz_busy", rd_busy, 8);
    chk("frz_state", rd_state, 1);
    ap_done[0] = 1'b1; tick();
    ap_done[0] = 1'b0;
    rd(0);
    chk("frz_txn", rd_txn, 1);
    chk("frz_maxlat", rd_max_lat, 5);
    chk("frz_state_idle", rd_state, 0);
    chk("frz_hold", frozen, 1);

    // Clear: statistics and frozen to zero, FSM untouched.
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("clr_frozen", frozen, 0);
    rd(0);
    chk("clr_busy", rd_busy, 0);
    chk("clr_txn", rd_txn, 0);
    chk("clr_maxlat", rd_max_lat, 0);
    rd(3);
    chk("clr_stall", rd_stall, 0);
    ap_start[1] = 1'b1; tick();
    ap_start[1] = 1'b0;
    clr = 1'b1; tick();
    clr = 1'b0;
    rd(1);
    chk("clr_fsm_state", rd_state, 1);
    chk("clr_fsm_busy", rd_busy, 0);
    ap_done[1] = 1'b1; tick();
    ap_done[1] = 1'b0;
    rd(1);
    chk("clr_lat_restart", rd_max_lat, 2);
    chk("clr_lat_txn", rd_txn, 1);
    chk("clr_lat_busy", rd_busy, 2);

    // Reset mid-run with frozen set and readout registers non-zero.
    finish = 1'b1; tick();
    finish = 1'b0;
    ap_start[0] = 1'b1; tick();
    ap_start[0] = 1'b0; tick();
    reset = 1'b0; rd_req = 1'b1; rd_ch = '0;
    ticks(2);
    chk("rst_valid", rd_valid, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_txn", rd_txn, 0);
    chk("rst_frozen", frozen, 0);
    reset = 1'b1; rd_req = 1'b0;
    rd(0);
    chk("rst_rd_valid", rd_valid, 1);
    chk("rst_rd_state", rd_state, 0);
    chk("rst_rd_busy", rd_busy, 0);
    rd(6);
    chk("rst_oor_valid", rd_valid, 1);
    chk("rst_oor_busy", rd_busy, 0);
    tick();
    chk("end_valid", rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
